// File: rtl/tremolo_lfo.sv
// Stereo tremolo with a per-frame phase-accumulator LFO.
// A square or triangle LFO is scaled by a depth setting to form a gain. Both channels are
// multiplied by that gain. The pipeline has a fixed latency of two cycles. With enable_i low
// the gain is forced to unity, so samples pass through unchanged with the same latency.
//
// Ports:
//   clk_i         system clock
//   reset_i       synchronous active-high reset; clears phase, pipeline and outputs
//   enable_i      1 = apply tremolo, 0 = bypass (unity gain)
//   wave_i        0 = square LFO, 1 = triangle LFO
//   rate_i        phase increment per accepted frame
//   depth_i       modulation depth, 0 = none, 255 = max
//   in_valid_i    one-cycle strobe: dinl_i/dinr_i hold a new stereo frame
//   dinl_i/dinr_i signed input samples
//   out_valid_o   one-cycle strobe: doutl_o/doutr_o hold a processed frame
//   doutl_o/doutr_o signed output samples, held while out_valid_o is low
//   lfo_out_o     unipolar LFO value of the most recent output frame
module tremolo_lfo #(
  parameter int unsigned DataW  = 24,
  parameter int unsigned PhaseW = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              wave_i,
  input  logic [PhaseW-1:0] rate_i,
  input  logic [7:0]        depth_i,
  input  logic              in_valid_i,
  input  logic [DataW-1:0]  dinl_i,
  input  logic [DataW-1:0]  dinr_i,
  output logic              out_valid_o,
  output logic [DataW-1:0]  doutl_o,
  output logic [DataW-1:0]  doutr_o,
  output logic [7:0]        lfo_out_o
);

  // Phase accumulator; the frame being accepted sees the pre-increment value.
  logic [PhaseW-1:0] phase_q, phase_d;

  logic [7:0]  tri_t;
  logic [7:0]  lfo_d;
  logic [15:0] depth_prod;
  logic [8:0]  gain_d;

  always_comb begin
    phase_d = phase_q;
    if (in_valid_i) begin
      phase_d = phase_q + rate_i;
    end
  end

  always_comb begin
    tri_t = phase_q[PhaseW-2 -: 8];
    if (wave_i) begin
      // Folding on the MSB keeps the triangle continuous across the phase wrap.
      lfo_d = phase_q[PhaseW-1] ? ~tri_t : tri_t;
    end else begin
      lfo_d = {8{phase_q[PhaseW-1]}};
    end
    depth_prod = {8'd0, depth_i} * {8'd0, lfo_d};
    // Gain spans 2..256; 256 is exact unity after the >>> 8.
    gain_d     = enable_i ? (9'd256 - {1'b0, depth_prod[15:8]}) : 9'd256;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Stage 1: capture samples, gain and LFO value of the accepted frame.
  logic             s1_valid_q;
  logic [DataW-1:0] s1_l_q, s1_r_q;
  logic [8:0]       s1_gain_q;
  logic [7:0]       s1_lfo_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_l_q     <= '0;
      s1_r_q     <= '0;
      s1_gain_q  <= '0;
      s1_lfo_q   <= '0;
    end else begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_l_q    <= dinl_i;
        s1_r_q    <= dinr_i;
        s1_gain_q <= gain_d;
        s1_lfo_q  <= lfo_d;
      end
    end
  end

  // Stage 2: signed sample times unsigned gain. Operands are extended to a common width so the
  // multiply is fully signed; the gain gets a zero top bit to stay positive.
  logic signed [DataW+9:0] l_ext, r_ext, g_ext;
  logic signed [DataW+9:0] prod_l, prod_r;

  always_comb begin
    l_ext  = $signed({{10{s1_l_q[DataW-1]}}, s1_l_q});
    r_ext  = $signed({{10{s1_r_q[DataW-1]}}, s1_r_q});
    g_ext  = $signed({{(DataW + 1){1'b0}}, s1_gain_q});
    prod_l = l_ext * g_ext;
    prod_r = r_ext * g_ext;
  end

  logic             out_valid_q;
  logic [DataW-1:0] doutl_q, doutr_q;
  logic [7:0]       lfo_out_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      doutl_q     <= '0;
      doutr_q     <= '0;
      lfo_out_q   <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        // Taking bits above 8 is an arithmetic shift right by 8 (floor toward -inf).
        doutl_q   <= prod_l[DataW+7:8];
        doutr_q   <= prod_r[DataW+7:8];
        lfo_out_q <= s1_lfo_q;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign doutl_o     = doutl_q;
  assign doutr_o     = doutr_q;
  assign lfo_out_o   = lfo_out_q;

  // Bits that are dropped by construction (g <= 256 means the top product bits are sign copies).
  logic unused_bits;
  assign unused_bits = ^{depth_prod[7:0], phase_q[PhaseW-10:0],
                         prod_l[DataW+9:DataW+8], prod_l[7:0],
                         prod_r[DataW+9:DataW+8], prod_r[7:0]};

endmodule

// File: tb/tb_tremolo_lfo.sv
module tb_tremolo_lfo;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        wave;
  logic [15:0] rate;
  logic [7:0]  depth;
  logic        in_valid;
  logic [23:0] dinl, dinr;
  logic        out_valid;
  logic [23:0] doutl, doutr;
  logic [7:0]  lfo_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tremolo_lfo dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .enable_i    (enable),
    .wave_i      (wave),
    .rate_i      (rate),
    .depth_i     (depth),
    .in_valid_i  (in_valid),
    .dinl_i      (dinl),
    .dinr_i      (dinr),
    .out_valid_o (out_valid),
    .doutl_o     (doutl),
    .doutr_o     (doutr),
    .lfo_out_o   (lfo_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge: drives one frame, returns two negedges later when its
  // output is visible.
  task automatic send(input logic [23:0] l, input logic [23:0] r);
    dinl     = l;
    dinr     = r;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    wave     = 1'b0;
    rate     = 16'h0000;
    depth    = 8'd0;
    in_valid = 1'b1;
    dinl     = 24'h111111;
    dinr     = 24'h222222;

    // 1: reset held 3 cycles with frames strobing
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_doutl", {8'd0, doutl}, 32'd0);
      check_eq("rst_doutr", {8'd0, doutr}, 32'd0);
      check_eq("rst_lfo", {24'd0, lfo_out}, 32'd0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    idle(2);
    check_eq("rst_after_valid", {31'd0, out_valid}, 32'd0);

    // 2: bypass is bit-exact, including the most negative value
    enable = 1'b0;
    depth  = 8'd255;
    rate   = 16'h0000;
    send(24'h123456, 24'h800000);
    check_eq("byp_valid", {31'd0, out_valid}, 32'd1);
    check_eq("byp_doutl", {8'd0, doutl}, 32'h123456);
    check_eq("byp_doutr", {8'd0, doutr}, 32'h800000);
    @(negedge clk);
    check_eq("byp_valid_pulse", {31'd0, out_valid}, 32'd0);
    check_eq("byp_hold", {8'd0, doutl}, 32'h123456);
    idle(1);

    // 3: square LFO, full depth, half-cycle per frame
    enable = 1'b1;
    wave   = 1'b0;
    depth  = 8'd255;
    rate   = 16'h8000;
    for (int k = 0; k < 4; k++) begin
      send(24'h100000, 24'h000100);
      check_eq("sq_valid", {31'd0, out_valid}, 32'd1);
      check_eq("sq_doutl", {8'd0, doutl}, (k % 2 == 0) ? 32'h100000 : 32'h002000);
      check_eq("sq_doutr", {8'd0, doutr}, (k % 2 == 0) ? 32'h000100 : 32'h000002);
      check_eq("sq_lfo", {24'd0, lfo_out}, (k % 2 == 0) ? 32'd0 : 32'd255);
      idle(2);
    end
    // phase is back to 0 after four half-turns

    // 4: triangle, half depth
    wave  = 1'b1;
    depth = 8'd128;
    rate  = 16'h1000;
    send(24'hFFFF00, 24'h7FFFFF);
    check_eq("tri0_lfo", {24'd0, lfo_out}, 32'd0);
    check_eq("tri0_doutl", {8'd0, doutl}, 32'h00FFFF00);
    check_eq("tri0_doutr", {8'd0, doutr}, 32'h007FFFFF);
    send(24'hFFFF00, 24'h7FFFFF);
    check_eq("tri1_lfo", {24'd0, lfo_out}, 32'd32);
    check_eq("tri1_doutl", {8'd0, doutl}, 32'h00FFFF10);
    check_eq("tri1_doutr", {8'd0, doutr}, 32'h0077FFFF);

    // 5: back-to-back frames across the phase wrap
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wave  = 1'b1;
    depth = 8'd255;
    rate  = 16'hFFFF;
    for (int i = 0; i < 12; i++) begin
      if (i >= 1) begin
        check_eq("b2b_valid", {31'd0, out_valid}, (i >= 2 && i < 10) ? 32'd1 : 32'd0);
        if (i >= 2 && i < 10) begin
          check_eq("b2b_doutl", {8'd0, doutl}, 32'((i - 2) * 16 + 1));
          check_eq("b2b_lfo", {24'd0, lfo_out}, 32'd0);
        end
      end
      in_valid = (i < 8);
      dinl     = 24'(i * 16 + 1);
      dinr     = 24'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;

    // 6: reset while frames are in flight discards them and zeroes the phase
    wave  = 1'b1;
    rate  = 16'h4000;
    depth = 8'd255;
    dinl  = 24'h0ABCDE;
    in_valid = 1'b1;
    @(negedge clk);
    dinl  = 24'h012345;
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
      check_eq("flush_doutl", {8'd0, doutl}, 32'd0);
      @(negedge clk);
    end
    rate = 16'h0000;
    send(24'h054321, 24'hFEDCBA);
    check_eq("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check_eq("post_rst_lfo", {24'd0, lfo_out}, 32'd0);
    check_eq("post_rst_doutl", {8'd0, doutl}, 32'h054321);
    check_eq("post_rst_doutr", {8'd0, doutr}, 32'hFEDCBA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
